// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared constants and helpers for the branch history table:
//                MIPS conditional-branch opcodes, branch decode and the
//                saturating-counter next-state function.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  // Widest counter the shared next-state helper supports.
  localparam int c_CNT_W_MAX = 8;

  // True for the two conditional-branch opcodes the predictor handles.
  function automatic logic is_branch(input logic [5:0] opcode);
    return (opcode == OP_BEQ) || (opcode == OP_BNE);
  endfunction

  // Counter step towards taken / not-taken; sticks at all-ones and at zero.
  // The counter is zero-extended to c_CNT_W_MAX and its real width passed
  // in, so one function serves every CNT_BITS up to c_CNT_W_MAX.
  function automatic logic [c_CNT_W_MAX-1:0] sat_cnt_next(
    input logic [c_CNT_W_MAX-1:0] cnt,
    input logic                   taken,
    input int                     bits
  );
    logic [c_CNT_W_MAX-1:0] top;
    top = (c_CNT_W_MAX'(1) << bits) - c_CNT_W_MAX'(1);
    if (taken) begin
      return (cnt >= top) ? top : cnt + c_CNT_W_MAX'(1);
    end
    return (cnt == '0) ? '0 : cnt - c_CNT_W_MAX'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_sat_counter_array.sv
`default_nettype none
// ============================================================================
//  Module      : bp_sat_counter_array
//  Description : Table of CNT_BITS saturating counters with one asynchronous
//                read port and one training port. The training port carries
//                the outcome only; the array does its own read-modify-write.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_sat_counter_array
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int CNT_BITS   = 2,
  parameter int INIT_CNT   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic [CNT_BITS-1:0]   rd_cnt,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_taken
);

  localparam int c_ENTRIES = 1 << INDEX_BITS;

  logic [CNT_BITS-1:0] r_cnt [c_ENTRIES];

  assign rd_cnt = r_cnt[rd_idx];

  // Reset every entry to the initial bias; train one entry per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_ENTRIES; i++) begin
        r_cnt[i] <= CNT_BITS'(INIT_CNT);
      end
    end else if (wr_en) begin
      r_cnt[wr_idx] <= CNT_BITS'(sat_cnt_next(c_CNT_W_MAX'(r_cnt[wr_idx]), wr_taken, CNT_BITS));
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor_bht.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_bht
//  Description : Branch history table of saturating counters. Combinational
//                lookup in ID for beq/bne, training in EX with a write-through
//                bypass when both hit the same entry, registered mispredict
//                pulse and saturating branch / mispredict statistics.
//                Optional macro BHT_GSHARE_EN: XOR a global history register
//                into the table index (gshare).
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int CNT_BITS   = 2,
  parameter int INIT_CNT   = 1,
  parameter int STAT_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           lk_pc,
  input  logic [31:0]           lk_ins,
  output logic                  lk_predict,
  output logic [INDEX_BITS-1:0] lk_ghr,
  input  logic                  up_valid,
  input  logic [31:0]           up_pc,
  input  logic [INDEX_BITS-1:0] up_ghr,
  input  logic                  up_taken,
  input  logic                  up_predicted,
  output logic                  mispredict,
  output logic [STAT_BITS-1:0]  stat_branches,
  output logic [STAT_BITS-1:0]  stat_mispred
);

  localparam logic [STAT_BITS-1:0] c_STAT_MAX = {STAT_BITS{1'b1}};

  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [INDEX_BITS-1:0] w_up_idx;
  logic [CNT_BITS-1:0]   w_rd_cnt;
  logic [CNT_BITS-1:0]   w_lk_cnt;
  logic                  w_bypass;
  logic                  w_mis;
  logic                  r_mispredict;
  logic [STAT_BITS-1:0]  r_stat_branches;
  logic [STAT_BITS-1:0]  r_stat_mispred;

`ifdef BHT_GSHARE_EN
  logic [INDEX_BITS-1:0] r_ghr;

  // History advances only on resolved branches, so it is never speculative.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ghr <= '0;
    end else if (up_valid) begin
      r_ghr <= {r_ghr[INDEX_BITS-2:0], up_taken};
    end
  end

  assign w_lk_idx = lk_pc[INDEX_BITS+1:2] ^ r_ghr;
  assign w_up_idx = up_pc[INDEX_BITS+1:2] ^ up_ghr;
  assign lk_ghr   = r_ghr;

  // Address bits outside the index and the non-opcode fields are not needed.
  logic w_unused;
  assign w_unused = ^{lk_pc[31:INDEX_BITS+2], lk_pc[1:0],
                      up_pc[31:INDEX_BITS+2], up_pc[1:0], lk_ins[25:0]};
`else
  assign w_lk_idx = lk_pc[INDEX_BITS+1:2];
  assign w_up_idx = up_pc[INDEX_BITS+1:2];
  assign lk_ghr   = '0;

  // Without gshare the carried history is ignored, as are the address bits
  // outside the index and the non-opcode instruction fields.
  logic w_unused;
  assign w_unused = ^{up_ghr, lk_pc[31:INDEX_BITS+2], lk_pc[1:0],
                      up_pc[31:INDEX_BITS+2], up_pc[1:0], lk_ins[25:0]};
`endif

  bp_sat_counter_array #(
    .INDEX_BITS (INDEX_BITS),
    .CNT_BITS   (CNT_BITS),
    .INIT_CNT   (INIT_CNT)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (w_lk_idx),
    .rd_cnt   (w_rd_cnt),
    .wr_en    (up_valid),
    .wr_idx   (w_up_idx),
    .wr_taken (up_taken)
  );

  // When training hits the looked-up entry, the read port already holds that
  // entry's old value, so applying the step here yields the post-update count.
  always_comb begin
    w_bypass = up_valid && (w_up_idx == w_lk_idx);
    w_lk_cnt = w_rd_cnt;
    if (w_bypass) begin
      w_lk_cnt = CNT_BITS'(sat_cnt_next(c_CNT_W_MAX'(w_rd_cnt), up_taken, CNT_BITS));
    end
    lk_predict = is_branch(lk_ins[31:26]) & w_lk_cnt[CNT_BITS-1];
  end

  assign w_mis = up_valid & (up_taken ^ up_predicted);

  // One-cycle mispredict pulse and statistics that stick at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mispredict    <= 1'b0;
      r_stat_branches <= '0;
      r_stat_mispred  <= '0;
    end else begin
      r_mispredict <= w_mis;
      if (up_valid && (r_stat_branches != c_STAT_MAX)) begin
        r_stat_branches <= r_stat_branches + 1'b1;
      end
      if (w_mis && (r_stat_mispred != c_STAT_MAX)) begin
        r_stat_mispred <= r_stat_mispred + 1'b1;
      end
    end
  end

  assign mispredict    = r_mispredict;
  assign stat_branches = r_stat_branches;
  assign stat_mispred  = r_stat_mispred;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_bht.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor_bht
//  Description : Scoreboard bench for branch_predictor_bht. A behavioural
//                model predicts every output; expectations are queued when
//                stimulus is driven and popped when the DUT output is sampled.
//                Build with BHT_GSHARE_EN to exercise the gshare variant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_bht;

  localparam int IB = 6;
  localparam int SB = 4;
  localparam int STAT_MAX = (1 << SB) - 1;

  localparam logic [31:0] INS_BEQ = 32'h1000_0000;
  localparam logic [31:0] INS_BNE = 32'h1400_0000;
  localparam logic [31:0] INS_ADD = 32'h0000_0020;

  logic          clk;
  logic          reset;
  logic [31:0]   lk_pc;
  logic [31:0]   lk_ins;
  logic          lk_predict;
  logic [IB-1:0] lk_ghr;
  logic          up_valid;
  logic [31:0]   up_pc;
  logic [IB-1:0] up_ghr;
  logic          up_taken;
  logic          up_predicted;
  logic          mispredict;
  logic [SB-1:0] stat_branches;
  logic [SB-1:0] stat_mispred;

  branch_predictor_bht #(
    .INDEX_BITS (IB),
    .CNT_BITS   (2),
    .INIT_CNT   (1),
    .STAT_BITS  (SB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .lk_pc         (lk_pc),
    .lk_ins        (lk_ins),
    .lk_predict    (lk_predict),
    .lk_ghr        (lk_ghr),
    .up_valid      (up_valid),
    .up_pc         (up_pc),
    .up_ghr        (up_ghr),
    .up_taken      (up_taken),
    .up_predicted  (up_predicted),
    .mispredict    (mispredict),
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state.
  int          mcnt [64];
  logic [IB-1:0] mghr;
  int          mb, mm;
  logic        mmis;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] got);
    exp_t e;
    if (sbq.size() == 0) begin
      check_eq("scoreboard_underflow", got, 32'hDEAD_BEEF);
    end else begin
      e = sbq.pop_front();
      check_eq(e.tag, got, e.exp);
    end
  endtask

  function automatic int sat(input int c, input bit t);
    if (t) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  function automatic logic [IB-1:0] lidx(input logic [31:0] pc);
`ifdef BHT_GSHARE_EN
    return pc[7:2] ^ mghr;
`else
    return pc[7:2];
`endif
  endfunction

  function automatic logic [IB-1:0] uidx(input logic [31:0] pc, input logic [IB-1:0] g);
`ifdef BHT_GSHARE_EN
    return pc[7:2] ^ g;
`else
    return (g == g) ? pc[7:2] : pc[7:2];
`endif
  endfunction

  // Expected lookup result for the currently driven inputs.
  function automatic logic exp_pred();
    logic [IB-1:0] li;
    int c;
    bit br;
    li = lidx(lk_pc);
    c  = mcnt[li];
    if (up_valid && (uidx(up_pc, up_ghr) == li)) c = sat(c, up_taken);
    br = (lk_ins[31:26] == 6'b000100) || (lk_ins[31:26] == 6'b000101);
    return br && (c >= 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mcnt[i] = 1;
    mghr = '0;
    mb   = 0;
    mm   = 0;
    mmis = 1'b0;
  endtask

  task automatic check_regs();
    push_exp("mispredict", 32'(mmis));
    push_exp("stat_branches", 32'(mb));
    push_exp("stat_mispred", 32'(mm));
    pop_check(32'(mispredict));
    pop_check(32'(stat_branches));
    pop_check(32'(stat_mispred));
  endtask

  // One pipeline cycle: drive at negedge, check lookup before the edge,
  // advance the model on the edge and check registered outputs after it.
  task automatic cyc(input logic [31:0] lpc, input logic [31:0] lins,
                     input bit uv, input logic [31:0] upc, input bit ut, input bit upd);
    logic [IB-1:0] ui;
    @(negedge clk);
    lk_pc        = lpc;
    lk_ins       = lins;
    up_valid     = uv;
    up_pc        = upc;
    up_taken     = ut;
    up_predicted = upd;
`ifdef BHT_GSHARE_EN
    up_ghr = mghr;
`else
    up_ghr = IB'($urandom);
`endif
    push_exp("lk_predict", 32'(exp_pred()));
    push_exp("lk_ghr", 32'(mghr));
    #2;
    pop_check(32'(lk_predict));
    pop_check(32'(lk_ghr));
    @(posedge clk);
    ui = uidx(upc, up_ghr);
    mmis = uv && (ut != upd);
    if (uv) begin
      mcnt[ui] = sat(mcnt[ui], ut);
      mb = (mb == STAT_MAX) ? STAT_MAX : mb + 1;
      if (ut != upd) mm = (mm == STAT_MAX) ? STAT_MAX : mm + 1;
`ifdef BHT_GSHARE_EN
      mghr = {mghr[IB-2:0], ut};
`endif
    end
    #1;
    check_regs();
  endtask

  // Asynchronous reset asserted between edges, with an update pending.
  task automatic async_reset_check();
    @(negedge clk);
    lk_pc = 32'h40; lk_ins = INS_BEQ;
    up_valid = 1'b1; up_pc = 32'h40; up_taken = 1'b1; up_predicted = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    push_exp("rst_lk_predict", 32'(exp_pred()));
    push_exp("rst_lk_ghr", 32'(mghr));
    pop_check(32'(lk_predict));
    pop_check(32'(lk_ghr));
    check_regs();
    @(posedge clk);
    #1;
    check_regs();
    @(negedge clk);
    reset = 1'b0;
    up_valid = 1'b0;
  endtask

  logic [31:0] pcs  [4];
  logic [31:0] inss [3];

  initial begin
    pcs[0] = 32'h40; pcs[1] = 32'h44; pcs[2] = 32'h80; pcs[3] = 32'h140;
    inss[0] = INS_BEQ; inss[1] = INS_BNE; inss[2] = INS_ADD;

    reset = 1'b1;
    lk_pc = 32'h1234; lk_ins = INS_BEQ;
    up_valid = 1'b0; up_pc = '0; up_ghr = '0; up_taken = 1'b0; up_predicted = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_lk_predict", 32'(lk_predict), 32'd0);
    check_regs();
    @(negedge clk);
    reset = 1'b0;

    // Train pc 0x40 towards taken, then look it up, then saturate.
    cyc(32'h100, INS_BEQ, 1, 32'h40, 1, 0);
    cyc(32'h100, INS_BEQ, 1, 32'h40, 1, 1);
    cyc(32'h40,  INS_BEQ, 0, 32'h0,  0, 0);
`ifndef BHT_GSHARE_EN
    check_eq("trained_beq_taken", 32'(lk_predict), 32'd1);
`endif
    cyc(32'h40,  INS_BEQ, 1, 32'h40, 1, 1);
    cyc(32'h40,  INS_BNE, 0, 32'h0,  0, 0);
    // Non-branch opcode never predicts taken; aliasing PC shares the entry.
    cyc(32'h40,  INS_ADD, 0, 32'h0,  0, 0);
    cyc(32'h140, INS_BNE, 0, 32'h0,  0, 0);
    // Same-cycle write-through bypass on a fresh entry.
    cyc(32'h80,  INS_BEQ, 1, 32'h80, 1, 0);
`ifndef BHT_GSHARE_EN
    check_eq("bypass_taken", 32'(lk_predict), 32'd1);
`endif
    // Drive an entry down past zero.
    for (int i = 0; i < 5; i++) cyc(32'h40, INS_BEQ, 1, 32'h40, 0, 1);
    // Twenty mispredictions: statistics must stick at all-ones.
    for (int i = 0; i < 20; i++) cyc(32'hC4, INS_BNE, 1, 32'hC0, i[0], ~i[0]);
    check_eq("stat_mispred_sat", 32'(stat_mispred), 32'(STAT_MAX));

    async_reset_check();
    cyc(32'h40, INS_BEQ, 0, 32'h0, 0, 0);

`ifdef BHT_GSHARE_EN
    // History taken, taken, not-taken from a clean reset.
    cyc(32'h200, INS_ADD, 1, 32'h200, 1, 1);
    cyc(32'h200, INS_ADD, 1, 32'h200, 1, 1);
    cyc(32'h200, INS_ADD, 1, 32'h200, 0, 0);
    check_eq("ghr_history", 32'(lk_ghr), 32'h06);
    cyc(32'h40, INS_BEQ, 1, 32'h40, 1, 1);
    cyc(32'h40, INS_BEQ, 0, 32'h0, 0, 0);
`endif

    // Mixed random traffic over a few aliasing and distinct PCs.
    for (int i = 0; i < 40; i++) begin
      cyc(pcs[$urandom_range(0, 3)], inss[$urandom_range(0, 2)],
          1'($urandom_range(0, 1)), pcs[$urandom_range(0, 3)],
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    check_eq("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
